maze_path_checker: RTL and testbench

- Consumer end of the maze solver's `Move` stream.
- Accepts a replayed sequence of 2-bit moves, walks a position over the same 16x16 wall map the solver uses, and checks that the path stays in bounds and off walls. The path passes only if it ends on the goal cell.
- Sits beside the solver in the maze subsystem and serves as an on-chip self-check of solver output.

---
 rtl/maze_path_checker.sv | 205 ++++++++++++++++++++
 tb/tb_maze_path_checker.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_path_checker.sv
// Replays a solver move stream over the shared wall map and flags whether the
// path stays in bounds, avoids walls and finishes on the goal cell.
module maze_path_checker #(
    parameter int unsigned N  = 16,
    parameter int unsigned AW = $clog2(N),
    parameter int unsigned CW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Start,
    input  logic              move_valid,
    input  logic [1:0]        Move,
    input  logic              move_last,
    output logic              move_ready,
    output logic [2*AW-1:0]   mem_addr,
    output logic              mem_rd,
    input  logic              mem_data,
    output logic              Pass,
    output logic              Fail,
    output logic              Busy,
    output logic [AW-1:0]     row,
    output logic [AW-1:0]     col,
    output logic [CW-1:0]     steps
);

    localparam logic [AW-1:0] MAX_POS   = AW'(N - 1);
    localparam logic [CW-1:0] STEPS_MAX = {CW{1'b1}};

    localparam logic [1:0] MV_UP    = 2'b00;
    localparam logic [1:0] MV_RIGHT = 2'b01;
    localparam logic [1:0] MV_LEFT  = 2'b10;
    localparam logic [1:0] MV_DOWN  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BOUND,
        ST_READ,
        ST_EVAL,
        ST_PASS,
        ST_FAIL
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      row_q, row_d;
    logic [AW-1:0]      col_q, col_d;
    logic [CW-1:0]      steps_q, steps_d;
    logic [1:0]         move_q, move_d;
    logic               last_q, last_d;
    logic [2*AW-1:0]    addr_q, addr_d;
    logic               rd_q, rd_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;

    logic [AW-1:0]      tgt_row;
    logic [AW-1:0]      tgt_col;
    logic               oob;

    // Target cell of the latched move and whether it leaves the grid.
    always_comb begin
        tgt_row = row_q;
        tgt_col = col_q;
        oob     = 1'b0;
        case (move_q)
            MV_UP: begin
                if (row_q == '0) oob = 1'b1;
                else             tgt_row = row_q - AW'(1);
            end
            MV_RIGHT: begin
                if (col_q == MAX_POS) oob = 1'b1;
                else                  tgt_col = col_q + AW'(1);
            end
            MV_LEFT: begin
                if (col_q == '0) oob = 1'b1;
                else             tgt_col = col_q - AW'(1);
            end
            MV_DOWN: begin
                if (row_q == MAX_POS) oob = 1'b1;
                else                  tgt_row = row_q + AW'(1);
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        steps_d = steps_q;
        move_d  = move_q;
        last_d  = last_q;
        addr_d  = addr_q;
        rd_d    = 1'b0;
        pass_d  = pass_q;
        fail_d  = fail_q;
        busy_d  = busy_q;
        ready_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (Start) begin
                    row_d   = '0;
                    col_d   = '0;
                    steps_d = '0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (move_valid) begin
                    move_d  = Move;
                    last_d  = move_last;
                    steps_d = (steps_q == STEPS_MAX) ? steps_q : steps_q + CW'(1);
                    state_d = ST_BOUND;
                end
            end
            ST_BOUND: begin
                if (oob) begin
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FAIL;
                end else begin
                    addr_d  = {tgt_row, tgt_col};
                    rd_d    = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                // addr_q still holds the target cell; mem_data is its wall bit.
                if (mem_data) begin
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FAIL;
                end else begin
                    row_d = addr_q[2*AW-1:AW];
                    col_d = addr_q[AW-1:0];
                    if (last_q) begin
                        busy_d = 1'b0;
                        if (addr_q == {MAX_POS, MAX_POS}) begin
                            pass_d  = 1'b1;
                            state_d = ST_PASS;
                        end else begin
                            fail_d  = 1'b1;
                            state_d = ST_FAIL;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            steps_q <= '0;
            move_q  <= '0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            steps_q <= steps_d;
            move_q  <= move_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign move_ready = ready_q;
    assign mem_addr   = addr_q;
    assign mem_rd     = rd_q;
    assign Pass       = pass_q;
    assign Fail       = fail_q;
    assign Busy       = busy_q;
    assign row        = row_q;
    assign col        = col_q;
    assign steps      = steps_q;

endmodule

// File: tb/tb_maze_path_checker.sv
// Scoreboard bench: directed walks push expected wall reads and walk results,
// a monitor pops them as the checker issues reads and raises Pass/Fail.
module tb_maze_path_checker;

    typedef struct packed {
        logic       pass;
        logic       fail;
        logic [3:0] row;
        logic [3:0] col;
        logic [9:0] steps;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       Start;
    logic       move_valid;
    logic [1:0] Move;
    logic       move_last;
    logic       move_ready;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic       mem_data;
    logic       Pass;
    logic       Fail;
    logic       Busy;
    logic [3:0] row;
    logic [3:0] col;
    logic [9:0] steps;

    logic       wall [256];
    res_t       res_q [$];
    logic [7:0] addr_q [$];

    int checks   = 0;
    int failures = 0;

    int   mr, mc, msteps;
    logic prev_done = 1'b0;

    maze_path_checker dut (
        .clk        (clk),
        .rst        (rst),
        .Start      (Start),
        .move_valid (move_valid),
        .Move       (Move),
        .move_last  (move_last),
        .move_ready (move_ready),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .Pass       (Pass),
        .Fail       (Fail),
        .Busy       (Busy),
        .row        (row),
        .col        (col),
        .steps      (steps)
    );

    always #5 clk = ~clk;

    // Synchronous wall-map memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= wall[mem_addr];
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: compare wall reads and walk completions against the scoreboard.
    always @(negedge clk) begin
        logic done;
        if (mem_rd === 1'b1) begin
            if (addr_q.size() == 0) chk("unexpected_mem_rd", 32'(mem_rd), 32'd0);
            else                    chk("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
        end
        done = Pass | Fail;
        if (done && !prev_done) begin
            if (res_q.size() == 0) chk("unexpected_result", 32'(done), 32'd0);
            else chk("walk_result", 32'({Pass, Fail, row, col, steps}), 32'(res_q.pop_front()));
        end
        prev_done = done;
    end

    // Reference walk: pushes the expected read address and any final result.
    task automatic model_move(input logic [1:0] m, input logic last);
        int  tr, tc;
        logic oob;
        msteps = (msteps == 1023) ? 1023 : msteps + 1;
        tr = mr; tc = mc; oob = 1'b0;
        case (m)
            2'b00: if (mr == 0)  oob = 1'b1; else tr = mr - 1;
            2'b01: if (mc == 15) oob = 1'b1; else tc = mc + 1;
            2'b10: if (mc == 0)  oob = 1'b1; else tc = mc - 1;
            default: if (mr == 15) oob = 1'b1; else tr = mr + 1;
        endcase
        if (oob) begin
            res_q.push_back('{1'b0, 1'b1, 4'(mr), 4'(mc), 10'(msteps)});
        end else begin
            addr_q.push_back(8'(tr * 16 + tc));
            if (wall[tr * 16 + tc]) begin
                res_q.push_back('{1'b0, 1'b1, 4'(mr), 4'(mc), 10'(msteps)});
            end else begin
                mr = tr; mc = tc;
                if (last) res_q.push_back('{(mr == 15 && mc == 15), !(mr == 15 && mc == 15),
                                            4'(mr), 4'(mc), 10'(msteps)});
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (move_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (move_ready !== 1'b1) chk("move_ready_timeout", 32'(move_ready), 32'd1);
    endtask

    task automatic send_move(input logic [1:0] m, input logic last);
        wait_ready();
        move_valid = 1'b1;
        Move       = m;
        move_last  = last;
        model_move(m, last);
        @(negedge clk);
        move_valid = 1'b0;
        move_last  = 1'b0;
    endtask

    task automatic start_walk();
        @(negedge clk);
        Start = 1'b1;
        @(negedge clk);
        Start  = 1'b0;
        mr     = 0;
        mc     = 0;
        msteps = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (Busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (Busy !== 1'b0) chk("busy_timeout", 32'(Busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_idle_regs(input string tag);
        chk({tag, "_pass"},  32'(Pass),       32'd0);
        chk({tag, "_fail"},  32'(Fail),       32'd0);
        chk({tag, "_busy"},  32'(Busy),       32'd0);
        chk({tag, "_ready"}, 32'(move_ready), 32'd0);
        chk({tag, "_rd"},    32'(mem_rd),     32'd0);
        chk({tag, "_addr"},  32'(mem_addr),   32'd0);
        chk({tag, "_pos"},   32'({row, col}), 32'd0);
        chk({tag, "_steps"}, 32'(steps),      32'd0);
    endtask

    initial begin
        int pulses, gap, n;
        rst = 1'b1; Start = 1'b0; move_valid = 1'b0; Move = 2'b00; move_last = 1'b0;
        mr = 0; mc = 0; msteps = 0;
        foreach (wall[i]) wall[i] = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_regs("reset");
        rst = 1'b0;

        // Staircase right/down to the goal on an open map.
        start_walk();
        chk("start_busy", 32'(Busy), 32'd1);
        for (int i = 0; i < 30; i++) send_move((i % 2 == 0) ? 2'b01 : 2'b11, (i == 29));
        wait_done();
        move_valid = 1'b1;
        repeat (6) @(negedge clk);
        move_valid = 1'b0;
        chk("pass_held",       32'(Pass),       32'd1);
        chk("pass_steps_held", 32'(steps),      32'd30);
        chk("pass_no_ready",   32'(move_ready), 32'd0);

        // Up from row 0 leaves the grid without a wall read.
        start_walk();
        chk("restart_clears_pass", 32'(Pass), 32'd0);
        send_move(2'b00, 1'b0);
        chk("oob_fail_not_yet", 32'(Fail), 32'd0);
        @(negedge clk);
        chk("oob_fail_latency", 32'(Fail), 32'd1);
        wait_done();

        // Wall directly right of the start cell.
        wall[1] = 1'b1;
        start_walk();
        send_move(2'b01, 1'b0);
        wait_done();
        chk("wall_col_stays", 32'(col), 32'd0);
        wall[1] = 1'b0;

        // Ends one cell short of the goal, then the same path one step further.
        start_walk();
        for (int i = 0; i < 29; i++) send_move((i < 15) ? 2'b11 : 2'b01, (i == 28));
        wait_done();
        start_walk();
        for (int i = 0; i < 30; i++) send_move((i < 15) ? 2'b11 : 2'b01, (i == 29));
        wait_done();

        // move_valid held high: one acceptance per four cycles.
        start_walk();
        move_valid = 1'b1; Move = 2'b01; move_last = 1'b0;
        pulses = 0; gap = 0; n = 0;
        while (n < 100) begin
            if (move_ready === 1'b1) begin
                if (pulses > 0) chk("ready_period", 32'(gap), 32'd4);
                chk("steps_per_pulse", 32'(steps), 32'(pulses));
                model_move(2'b01, 1'b0);
                pulses++;
                gap = 0;
            end
            if (pulses == 6) break;
            @(negedge clk);
            gap++;
            n++;
        end
        if (pulses < 6) chk("held_valid_pulses", 32'(pulses), 32'd6);
        @(negedge clk);
        move_valid = 1'b0;
        send_move(2'b01, 1'b1);
        wait_done();

        // Step counter saturates without failing the walk.
        start_walk();
        for (int i = 0; i < 1030; i++) send_move((i % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
        send_move(2'b01, 1'b1);
        wait_done();

        // Reset mid-walk, then a Start pulse during a walk is ignored.
        start_walk();
        for (int i = 0; i < 5; i++) send_move(2'b01, 1'b0);
        wait_ready();
        chk("pre_reset_steps", 32'(steps), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_regs("midwalk_reset");
        start_walk();
        chk("reset_start_pos",   32'({row, col}), 32'd0);
        chk("reset_start_steps", 32'(steps),      32'd0);
        chk("reset_start_busy",  32'(Busy),       32'd1);
        for (int i = 0; i < 2; i++) send_move(2'b01, 1'b0);
        wait_ready();
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        chk("ignored_start_steps", 32'(steps), 32'd2);
        chk("ignored_start_col",   32'(col),   32'd2);
        send_move(2'b01, 1'b0);
        send_move(2'b01, 1'b1);
        wait_done();

        repeat (2) @(negedge clk);
        chk("results_drained", 32'(res_q.size()),  32'd0);
        chk("reads_drained",   32'(addr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
